alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter N, default 12, ALU word width; operand/result width is 2*N.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 r0_valid, r1_valid  input  1 each  requester 0/1 request valid.
REQ-005 r0_ready, r1_ready  output  1 each  request accepted this cycle when valid&ready.
REQ-006 r0_op, r1_op  input  2 each  00 AND12, 01 ADD12, 10 ADD24, 11 AND24.
REQ-007 r0_a, r0_b, r1_a, r1_b  input  2N each  operands.
REQ-008 alu_in0, alu_in1  output  N each  operands driven to the external ALU.
REQ-009 alu_op  output  2  ALU opcode: 00 AND, 01 ADD.
REQ-010 alu_out  input  N; alu_cy  input  1; alu_zero  input  1  combinational ALU results.
REQ-011 rsp_valid  output  1  one-cycle result strobe; no backpressure.
REQ-012 rsp_id  output  1; rsp_data  output  2N; rsp_cy  output  1; rsp_zero  output  1.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, LO, HI, FIX, RSP.
REQ-015 In IDLE, a grant is computed combinationally; r<g>_ready is high only for the granted requester, and only in IDLE.
REQ-016 Arbitration is round-robin: a single valid requester wins; with both valid, the requester not served last wins; last_served resets to 1, so r0 wins first.
REQ-017 On accept, op, a, b and id are registered; IDLE->LO.
REQ-018 LO: alu_in0/alu_in1 = a[N-1:0]/b[N-1:0], alu_op = op[0] ^ op[1] (01 for ADD, 00 for AND); alu_out, alu_cy and alu_zero are captured as lo, c0 and z0.
REQ-019 LO->RSP for 12-bit ops; LO->HI for 24-bit ops.
REQ-020 HI: alu_in0/alu_in1 = upper halves, same alu_op; capture hi, c1 and z1; AND24 goes HI->RSP, ADD24 goes HI->FIX.
REQ-021 FIX (ADD24 only): alu_in0 = hi, alu_in1 = zero-extended c0, alu_op = 01; capture hi, c2 and z1; FIX->RSP.
REQ-022 In IDLE and RSP, alu_in0 = alu_in1 = 0 and alu_op = 00.
REQ-023 RSP: rsp_valid = 1 for exactly one cycle; RSP->IDLE; no request is accepted in RSP.
REQ-024 rsp_data: 12-bit ops give {N zeros, lo}; 24-bit ops give {hi, lo}.
REQ-025 rsp_cy: c0 for ADD12; c1|c2 for ADD24; always 0 for AND ops (alu_cy ignored, as the ALU holds a stale CY on AND).
REQ-026 rsp_zero: z0 for 12-bit ops; z0&z1 for 24-bit ops.
REQ-027 Accept-to-rsp_valid latency: 2 cycles for 12-bit ops, 3 for AND24, 4 for ADD24; throughput is one op per latency+1 cycles.
REQ-028 rsp_* hold their values until the next RSP; rsp_valid is 0 outside RSP.

Reset
REQ-029 rst_n low, asynchronously: state IDLE, last_served=1, all registers and outputs 0 (rsp_valid, busy, rsp_data, rsp_cy, rsp_zero).
REQ-030 Reset mid-operation aborts the op with no response; the first grant after release follows REQ-016.

Structure
REQ-031 Shared package alu_pkg: N, op encodings (OP_AND12, OP_ADD12, OP_ADD24, OP_AND24), ALU opcodes (ALU_AND, ALU_ADD) and the state enum.
REQ-032 One sub-module: rr_arb2 (2-way round-robin arbiter holding last_served), instantiated inside alu_sched.
REQ-033 The ALU stays external, connected via the alu_* ports; benches pair alu_sched with the team's 12-bit ALU.

Verification
REQ-034 Reset asserted mid-cycle -> all outputs 0 immediately, busy=0.
REQ-035 r0 ADD12 a=0x000FFF b=0x000001 -> 2 cycles after accept: rsp_data=0x000000, rsp_cy=1, rsp_zero=1, rsp_id=0.
REQ-036 r1 ADD24 a=0xFFFFFF b=0x000001 -> 4 cycles after accept: rsp_data=0x000000, rsp_cy=1, rsp_zero=1; and a=0x000FFF, b=0x000001 -> rsp_data=0x001000, rsp_cy=0, rsp_zero=0.
REQ-037 ADD12 0xFFF+0x001 followed by AND12 a=0x0F0 b=0x0FF -> second rsp_data=0x0000F0, rsp_cy=0, rsp_zero=0.
REQ-038 Both requesters held valid with AND12 -> grant order r0,r1,r0,r1; each rsp_id matches its accepted requester.
REQ-039 rst_n pulsed low during HI of an ADD24 -> no rsp_valid, state IDLE; after release with both valid -> r0 granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU scheduler.
//   N            - ALU word width (operands/results are 2*N wide)
//   OP_*         - request opcodes (12-bit / 24-bit AND and ADD)
//   ALU_*        - opcodes driven to the external N-bit ALU
//   state_t      - scheduler FSM states
package alu_pkg;

  localparam int N = 12;

  localparam logic [1:0] OP_AND12 = 2'b00;
  localparam logic [1:0] OP_ADD12 = 2'b01;
  localparam logic [1:0] OP_ADD24 = 2'b10;
  localparam logic [1:0] OP_AND24 = 2'b11;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_FIX  = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

  // Double-width ops need a second (upper-half) ALU pass.
  function automatic logic op_is_wide(input logic [1:0] op);
    return op[1];
  endfunction

  // The opcode encoding places ADD where the two bits differ.
  function automatic logic op_is_add(input logic [1:0] op);
    return op[0] ^ op[1];
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_req[1:0]  - request vector (bit g = requester g)
//   i_en        - grants are only issued while high
//   i_upd       - a grant was taken this cycle; remember the winner
//   i_upd_id    - id of the requester that was served
//   o_gnt[1:0]  - one-hot grant (combinational)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  input  logic       i_upd,
  input  logic       i_upd_id,
  output logic [1:0] o_gnt
);

  logic r_last;
  logic w_pick;

  // Remember the last served requester; reset value 1 lets r0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_upd) begin
      r_last <= i_upd_id;
    end else begin
      r_last <= r_last;
    end
  end

  // Winner selection: with both requesting, favour the one not served last.
  always_comb begin
    w_pick = 1'b0;
    o_gnt  = 2'b00;
    if (i_req == 2'b11) begin
      w_pick = ~r_last;
    end else begin
      w_pick = i_req[1];
    end
    if (i_en && (i_req != 2'b00)) begin
      o_gnt = w_pick ? 2'b10 : 2'b01;
    end else begin
      o_gnt = 2'b00;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: schedules 12/24-bit AND/ADD requests from two requesters onto a
// single external N-bit ALU, splitting wide ops into lower/upper passes plus
// a carry-fix pass for ADD24.
//   clk, rst_n                   - clock, asynchronous active-low reset
//   r0_*/r1_* valid/ready/op/a/b - requester handshakes and operands
//   alu_in0/alu_in1/alu_op       - operands and opcode to the ALU
//   alu_out/alu_cy/alu_zero      - combinational ALU results
//   rsp_valid/id/data/cy/zero    - one-cycle response strobe and held result
//   busy                         - scheduler is not idle
module alu_sched
  import alu_pkg::*;
#(
  parameter int N = alu_pkg::N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic [1:0]     r0_op,
  input  logic [2*N-1:0] r0_a,
  input  logic [2*N-1:0] r0_b,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic [1:0]     r1_op,
  input  logic [2*N-1:0] r1_a,
  input  logic [2*N-1:0] r1_b,
  output logic [N-1:0]   alu_in0,
  output logic [N-1:0]   alu_in1,
  output logic [1:0]     alu_op,
  input  logic [N-1:0]   alu_out,
  input  logic           alu_cy,
  input  logic           alu_zero,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_data,
  output logic           rsp_cy,
  output logic           rsp_zero,
  output logic           busy
);

  state_t r_state;
  state_t w_next;

  logic [1:0]     w_gnt;
  logic           w_accept;
  logic           w_acc_id;

  logic [1:0]     r_op;
  logic [2*N-1:0] r_a;
  logic [2*N-1:0] r_b;
  logic           r_id;
  logic [N-1:0]   r_lo;
  logic [N-1:0]   r_hi;
  logic           r_c0;
  logic           r_c1;
  logic           r_z0;

  logic           r_rsp_valid;
  logic           r_rsp_id;
  logic [2*N-1:0] r_rsp_data;
  logic           r_rsp_cy;
  logic           r_rsp_zero;
  logic           r_busy;

  logic [2*N-1:0] w_fin_data;
  logic           w_fin_cy;
  logic           w_fin_zero;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    ({r1_valid, r0_valid}),
    .i_en     (r_state == ST_IDLE),
    .i_upd    (w_accept),
    .i_upd_id (w_acc_id),
    .o_gnt    (w_gnt)
  );

  assign r0_ready = w_gnt[0];
  assign r1_ready = w_gnt[1];
  assign w_accept = (r0_valid & r0_ready) | (r1_valid & r1_ready);
  assign w_acc_id = r1_valid & r1_ready;

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_cy    = r_rsp_cy;
  assign rsp_zero  = r_rsp_zero;
  assign busy      = r_busy;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = w_accept ? ST_LO : ST_IDLE;
      ST_LO:   w_next = op_is_wide(r_op) ? ST_HI : ST_RSP;
      ST_HI:   w_next = (r_op == OP_ADD24) ? ST_FIX : ST_RSP;
      ST_FIX:  w_next = ST_RSP;
      ST_RSP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // ALU operand/opcode steering per pass; FIX folds the low carry into hi.
  always_comb begin
    alu_in0 = '0;
    alu_in1 = '0;
    alu_op  = ALU_AND;
    case (r_state)
      ST_LO: begin
        alu_in0 = r_a[N-1:0];
        alu_in1 = r_b[N-1:0];
        alu_op  = {1'b0, op_is_add(r_op)};
      end
      ST_HI: begin
        alu_in0 = r_a[2*N-1:N];
        alu_in1 = r_b[2*N-1:N];
        alu_op  = {1'b0, op_is_add(r_op)};
      end
      ST_FIX: begin
        alu_in0 = r_hi;
        alu_in1 = {{(N-1){1'b0}}, r_c0};
        alu_op  = ALU_ADD;
      end
      default: begin
        alu_in0 = '0;
        alu_in1 = '0;
        alu_op  = ALU_AND;
      end
    endcase
  end

  // Final result assembled from the last pass's live ALU outputs, so the
  // response registers hold it from the first RSP cycle. AND ops never
  // report carry because the ALU leaves a stale CY on AND.
  always_comb begin
    w_fin_data = '0;
    w_fin_cy   = 1'b0;
    w_fin_zero = 1'b0;
    case (r_state)
      ST_LO: begin
        w_fin_data = {{N{1'b0}}, alu_out};
        w_fin_cy   = (r_op == OP_ADD12) ? alu_cy : 1'b0;
        w_fin_zero = alu_zero;
      end
      ST_HI: begin
        w_fin_data = {alu_out, r_lo};
        w_fin_cy   = 1'b0;
        w_fin_zero = r_z0 & alu_zero;
      end
      ST_FIX: begin
        w_fin_data = {alu_out, r_lo};
        w_fin_cy   = r_c1 | alu_cy;
        w_fin_zero = r_z0 & alu_zero;
      end
      default: begin
        w_fin_data = '0;
        w_fin_cy   = 1'b0;
        w_fin_zero = 1'b0;
      end
    endcase
  end

  // Request capture on accept and per-pass ALU result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 2'b00;
      r_a  <= '0;
      r_b  <= '0;
      r_id <= 1'b0;
      r_lo <= '0;
      r_hi <= '0;
      r_c0 <= 1'b0;
      r_c1 <= 1'b0;
      r_z0 <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id <= w_acc_id;
            r_op <= w_acc_id ? r1_op : r0_op;
            r_a  <= w_acc_id ? r1_a  : r0_a;
            r_b  <= w_acc_id ? r1_b  : r0_b;
          end
        end
        ST_LO: begin
          r_lo <= alu_out;
          r_c0 <= alu_cy;
          r_z0 <= alu_zero;
        end
        ST_HI: begin
          r_hi <= alu_out;
          r_c1 <= alu_cy;
        end
        ST_FIX: begin
          r_hi <= alu_out;
        end
        default: begin
          r_lo <= r_lo;
        end
      endcase
    end
  end

  // Response and status registers; rsp_* hold until the next RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_cy    <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= (w_next == ST_RSP);
      r_busy      <= (w_next != ST_IDLE);
      if (w_next == ST_RSP) begin
        r_rsp_id   <= r_id;
        r_rsp_data <= w_fin_data;
        r_rsp_cy   <= w_fin_cy;
        r_rsp_zero <= w_fin_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;
  import alu_pkg::*;

  localparam int W = 2 * alu_pkg::N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_valid, r1_valid;
  logic          r0_ready, r1_ready;
  logic [1:0]    r0_op, r1_op;
  logic [W-1:0]  r0_a, r0_b, r1_a, r1_b;
  logic [11:0]   alu_in0, alu_in1, alu_out;
  logic [1:0]    alu_op;
  logic          alu_cy, alu_zero;
  logic          rsp_valid, rsp_id, rsp_cy, rsp_zero, busy;
  logic [W-1:0]  rsp_data;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cy(alu_cy), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_cy(rsp_cy), .rsp_zero(rsp_zero), .busy(busy)
  );

  // External 12-bit ALU; on AND its CY output is a stale, toggling bit.
  logic        stale_cy = 1'b0;
  logic [12:0] alu_sum;
  always @(posedge clk) stale_cy <= ~stale_cy;
  always_comb begin
    alu_sum = {1'b0, alu_in0} + {1'b0, alu_in1};
    if (alu_op == 2'b01) begin
      alu_out = alu_sum[11:0];
      alu_cy  = alu_sum[12];
    end else begin
      alu_out = alu_in0 & alu_in1;
      alu_cy  = stale_cy;
    end
    alu_zero = (alu_out == 12'd0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         cy;
    logic         zero;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  logic acc_log[$];
  int   checks = 0;
  int   errors = 0;

  logic         last_id, last_cy, last_zero;
  logic [W-1:0] last_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the 24-bit operands.
  function automatic exp_t model(input logic id, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    exp_t e;
    logic [12:0] s13;
    logic [24:0] s25;
    e.id = id; e.acc_cyc = c; e.cy = 1'b0;
    case (op)
      2'b00: begin e.data = {12'd0, a[11:0] & b[11:0]}; e.lat = 2; end
      2'b01: begin s13 = {1'b0, a[11:0]} + {1'b0, b[11:0]};
                   e.data = {12'd0, s13[11:0]}; e.cy = s13[12]; e.lat = 2; end
      2'b10: begin s25 = {1'b0, a} + {1'b0, b};
                   e.data = s25[23:0]; e.cy = s25[24]; e.lat = 4; end
      default: begin e.data = a & b; e.lat = 3; end
    endcase
    e.zero = (e.data == 24'd0);
    return e;
  endfunction

  // Monitor: every response must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        chk("rsp_data", {8'd0, rsp_data}, {8'd0, e.data});
        chk("rsp_cy", {31'd0, rsp_cy}, {31'd0, e.cy});
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
        chk("rsp_latency", cyc - e.acc_cyc, e.lat);
        last_id = rsp_id; last_data = rsp_data; last_cy = rsp_cy; last_zero = rsp_zero;
      end
    end
  end

  // Called at a falling edge; samples the handshake just before the rising edge.
  task automatic tick(output logic a0, output logic a1);
    #4;
    a0 = r0_valid && r0_ready;
    a1 = r1_valid && r1_ready;
    chk("ready_onehot", {31'd0, r0_ready & r1_ready}, 32'd0);
    if (busy) chk("ready_while_busy", {30'd0, r1_ready, r0_ready}, 32'd0);
    if (a0) begin q.push_back(model(1'b0, r0_op, r0_a, r0_b, cyc)); acc_log.push_back(1'b0); end
    if (a1) begin q.push_back(model(1'b1, r1_op, r1_a, r1_b, cyc)); acc_log.push_back(1'b1); end
    @(negedge clk);
  endtask

  task automatic issue(input logic id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic a0, a1;
    bit   done;
    done = 1'b0;
    if (!id) begin r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
    else     begin r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
    for (int i = 0; i < 20 && !done; i++) begin
      tick(a0, a1);
      done = id ? a1 : a0;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    if (!done) chk("issue_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic a0, a1;
    int   n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 40) begin tick(a0, a1); n++; end
    chk("drain_pending", q.size(), 32'd0);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = W'($urandom);
    if ($urandom_range(0, 3) == 0) v = 24'hFFFFFF;
    else if ($urandom_range(0, 3) == 0) v = {12'd0, v[11:0]};
    return v;
  endfunction

  initial begin
    logic a0, a1;
    int   n;
    rst_n = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_op = 2'b00; r1_op = 2'b00;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_data", {8'd0, rsp_data}, 32'd0);
    chk("rst_rsp_cy_zero", {30'd0, rsp_cy, rsp_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD12 carry out of the low word
    issue(1'b0, OP_ADD12, 24'h000FFF, 24'h000001);
    drain();
    chk("add12_dir", {5'd0, last_id, last_cy, last_zero, last_data}, {5'd0, 1'b0, 1'b1, 1'b1, 24'h000000});

    // ADD24 wrap to zero and ADD24 low-carry propagation
    issue(1'b1, OP_ADD24, 24'hFFFFFF, 24'h000001);
    drain();
    chk("add24_wrap_dir", {5'd0, last_id, last_cy, last_zero, last_data}, {5'd0, 1'b1, 1'b1, 1'b1, 24'h000000});
    issue(1'b1, OP_ADD24, 24'h000FFF, 24'h000001);
    drain();
    chk("add24_prop_dir", {6'd0, last_cy, last_zero, last_data}, {6'd0, 1'b0, 1'b0, 24'h001000});

    // AND12 after a carrying ADD12: stale carry must not leak
    issue(1'b0, OP_ADD12, 24'h000FFF, 24'h000001);
    issue(1'b0, OP_AND12, 24'h0000F0, 24'h0000FF);
    drain();
    chk("and12_after_add_dir", {6'd0, last_cy, last_zero, last_data}, {6'd0, 1'b0, 1'b0, 24'h0000F0});

    // Randomized traffic from both requesters
    for (int i = 0; i < 400; i++) begin
      if (!r0_valid && $urandom_range(0, 2) == 0) begin
        r0_valid = 1'b1; r0_op = 2'($urandom); r0_a = rand_word(); r0_b = rand_word();
      end
      if (!r1_valid && $urandom_range(0, 2) == 0) begin
        r1_valid = 1'b1; r1_op = 2'($urandom); r1_a = rand_word(); r1_b = rand_word();
      end
      tick(a0, a1);
      if (a0) r0_valid = 1'b0;
      if (a1) r1_valid = 1'b0;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    drain();

    // Reset in the HI pass of an ADD24 aborts it silently
    issue(1'b1, OP_ADD24, 24'hFFFFFF, 24'h000001);
    @(negedge clk);
    chk("busy_in_hi", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rsp_data", {8'd0, rsp_data}, 32'd0);
    chk("midrst_rsp_cy_zero", {30'd0, rsp_cy, rsp_zero}, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", {30'd0, busy, rsp_valid}, 32'd0);

    // Both held valid with AND12: grants alternate starting with r0
    acc_log.delete();
    r0_valid = 1'b1; r0_op = OP_AND12; r0_a = 24'h123ABC; r0_b = 24'h000F0F;
    r1_valid = 1'b1; r1_op = OP_AND12; r1_a = 24'h000555; r1_b = 24'h000FF0;
    n = 0;
    while (acc_log.size() < 4 && n < 40) begin tick(a0, a1); n++; end
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("rr_accept_count", acc_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      chk($sformatf("rr_order_%0d", i), {31'd0, acc_log[i]}, i % 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
